// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared states, default geometry and status bit positions for capture_ctrl
package capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_VSYNC,
    ST_CAPTURE,
    ST_DONE
  } cap_state_t;

  localparam int DEF_H_BYTES = 1280;
  localparam int DEF_V_LINES = 480;
  localparam int DEF_ADDR_W  = 20;

  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - rise/fall detector against a one-cycle registered copy of the input
module edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= 1'b0;
    else       r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;
  assign o_fall = ~i_d & r_q;

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - camera frame capture controller writing one frame into a byte frame buffer
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int H_BYTES = DEF_H_BYTES,
  parameter int V_LINES = DEF_V_LINES,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              abort,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_valid,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic [9:0]        line_cnt
);

  localparam int BC_W = $clog2(H_BYTES + 1);
  localparam logic [BC_W-1:0] H_BC      = BC_W'(H_BYTES);
  localparam logic [9:0]      LAST_LINE = 10'(V_LINES - 1);

  cap_state_t        r_state, w_state_nxt;
  logic [BC_W-1:0]   r_byte_cnt;
  logic [ADDR_W-1:0] r_line_base;
  logic [9:0]        r_line_cnt;
  logic              r_err_len;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;

  logic w_vs_rise, w_vs_fall, w_hr_rise, w_hr_fall;
  logic w_accept, w_drop, w_start_ok, w_last_line_end;

  edge_det u_vsync_edge (
    .i_clk  (CLK),
    .i_rst  (RESET),
    .i_d    (cam_vsync),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  edge_det u_href_edge (
    .i_clk  (CLK),
    .i_rst  (RESET),
    .i_d    (cam_href),
    .o_rise (w_hr_rise),
    .o_fall (w_hr_fall)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_start_ok      = 1'b0;
    w_accept        = 1'b0;
    w_drop          = 1'b0;
    w_last_line_end = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_start_ok  = 1'b1;
            w_state_nxt = ST_ARM;
          end
        end
        ST_ARM:   if (w_vs_rise) w_state_nxt = ST_VSYNC;
        ST_VSYNC: if (w_vs_fall) w_state_nxt = ST_CAPTURE;
        ST_CAPTURE: begin
          w_accept        = cam_href && cam_valid && (r_byte_cnt < H_BC);
          w_drop          = cam_href && cam_valid && (r_byte_cnt >= H_BC);
          w_last_line_end = w_hr_fall && (r_line_cnt == LAST_LINE);
          if (w_vs_rise || w_last_line_end) w_state_nxt = ST_DONE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_byte_cnt  <= '0;
      r_line_base <= '0;
      r_line_cnt  <= '0;
      r_err_len   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr <= r_line_base + ADDR_W'(r_byte_cnt);
        r_wr_data <= cam_data;
      end
      if (w_start_ok) begin
        r_byte_cnt  <= '0;
        r_line_base <= '0;
        r_line_cnt  <= '0;
        r_err_len   <= 1'b0;
      end else if (!abort && r_state == ST_CAPTURE) begin
        if (w_accept) r_byte_cnt <= r_byte_cnt + BC_W'(1);
        if (w_drop) r_err_len <= 1'b1;
        if (w_hr_fall) begin
          if (r_byte_cnt != H_BC) r_err_len <= 1'b1;
          r_line_cnt <= r_line_cnt + 10'd1;
          r_byte_cnt <= '0;
          // The base stops on the last line so it never points past the buffer.
          if (!w_last_line_end) r_line_base <= r_line_base + ADDR_W'(H_BYTES);
        end
        if (w_vs_rise && !w_last_line_end) r_err_len <= 1'b1;
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = (r_state == ST_ARM) || (r_state == ST_VSYNC) || (r_state == ST_CAPTURE);
  assign done     = (r_state == ST_DONE);
  assign err_len  = r_err_len;
  assign line_cnt = r_line_cnt;

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter H_BYTES, default 1280, bytes per line (640 px x 2 B).
REQ-002 SHALL have parameter V_LINES, default 480, lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 20, frame-buffer byte-address width.
REQ-004 SHALL have port CLK  in  1  system clock (MCLK domain); one clock only.
REQ-005 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle capture request (register 0x10 bit0 write).
REQ-007 SHALL have port abort  in  1  one-cycle cancel request.
REQ-008 SHALL have port cam_vsync  in  1  camera VSYNC, already synchronised to CLK.
REQ-009 SHALL have port cam_href  in  1  camera HREF, already synchronised to CLK.
REQ-010 SHALL have port cam_valid  in  1  byte strobe; cam_data is valid when high.
REQ-011 SHALL have port cam_data  in  8  camera byte.
REQ-012 SHALL have port wr_en  out  1  frame-buffer write strobe.
REQ-013 SHALL have port wr_addr  out  ADDR_W  frame-buffer byte address.
REQ-014 SHALL have port wr_data  out  8  frame-buffer write byte.
REQ-015 SHALL have port busy  out  1  capture in progress (status 0x14 bit1).
REQ-016 SHALL have port done  out  1  frame complete (status 0x14 bit0).
REQ-017 SHALL have port err_len  out  1  sticky line/frame length error (status 0x14 bit2).
REQ-018 SHALL have port line_cnt  out  10  lines completed in the current frame.

Function
REQ-019 SHALL implement states IDLE, ARM, VSYNC, CAPTURE and DONE.
REQ-020 SHALL detect VSYNC and HREF edges against a one-cycle registered copy of each input.
REQ-021 SHALL, on start in IDLE or DONE, enter ARM and clear done, err_len, line_cnt and the address counters; start in ARM, VSYNC or CAPTURE SHALL be ignored.
REQ-022 SHALL leave ARM only on a cam_vsync rising edge, entering VSYNC; a VSYNC already high at start SHALL NOT count as an edge.
REQ-023 SHALL leave VSYNC on a cam_vsync falling edge, entering CAPTURE.
REQ-024 SHALL, in CAPTURE, accept a byte when cam_href=1, cam_valid=1 and byte_cnt<H_BYTES; on the next cycle drive wr_en=1, wr_data=byte and wr_addr=line_base+byte_cnt (latency 1 cycle); then increment byte_cnt.
REQ-025 SHALL drop any valid byte with byte_cnt>=H_BYTES (no write) and set err_len.
REQ-026 SHALL, on a cam_href falling edge in CAPTURE: set err_len if byte_cnt!=H_BYTES; increment line_cnt; add H_BYTES to line_base; clear byte_cnt.
REQ-027 SHALL enter DONE the cycle after the HREF falling edge that makes line_cnt equal V_LINES.
REQ-028 SHALL, on a cam_vsync rising edge in CAPTURE before V_LINES lines, set err_len and enter DONE (short frame).
REQ-029 SHALL hold done=1 in DONE until the next start or RESET; busy SHALL equal 1 exactly in ARM, VSYNC and CAPTURE.
REQ-030 SHALL, on abort in any state, enter IDLE next cycle with wr_en=0, busy=0 and done=0, keeping err_len; abort SHALL win over a simultaneous start.
REQ-031 SHALL drive wr_en=0 outside CAPTURE, except for the single trailing write of a byte accepted on the last CAPTURE cycle.
REQ-032 SHALL use address arithmetic that never exceeds H_BYTES*V_LINES-1; counters SHALL NOT wrap within a frame.

Reset
REQ-033 SHALL, while RESET=1 at a CLK edge, set state IDLE and drive wr_en, wr_addr, wr_data, busy, done, err_len and line_cnt to 0; internal counters and edge registers SHALL also clear.
REQ-034 SHALL, on reset mid-capture, abandon the frame and issue no further writes.

Structure
REQ-035 SHALL take the state enumeration, default H_BYTES/V_LINES/ADDR_W constants and status bit positions from shared package capture_pkg.
REQ-036 SHALL instantiate sub-module edge_det (registered rise/fall detector) once per VSYNC and HREF.

Verification (H_BYTES=4, V_LINES=3)
REQ-037 SHALL verify a nominal frame: start, VSYNC pulse, 3 lines of bytes 0x00..0x0B -> writes addr 0..11 with matching data, done=1, err_len=0, line_cnt=3.
REQ-038 SHALL verify start with VSYNC already high -> no capture until the next rising edge; writes begin only after that VSYNC falls.
REQ-039 SHALL verify a long line (6 bytes on line 0) -> only addr 0..3 written, line 1 starts at addr 4, err_len=1, done=1.
REQ-040 SHALL verify a short frame (VSYNC rises after 2 lines) -> done=1, err_len=1, line_cnt=2, last write at addr 7.
REQ-041 SHALL verify abort asserted with start on the same cycle mid-line 1 -> IDLE next cycle, no further wr_en, busy=0, done=0.
REQ-042 SHALL verify RESET asserted during CAPTURE -> all outputs 0 the next cycle; a following start captures a full clean frame.
